fetch_unit: RTL and testbench

Instruction fetch stage that sits directly downstream of the 32 x 20-bit instruction memory. It owns the program counter, issues read requests to the memory (`enable`=1, `read_writenot`=1), and absorbs the memory's one-cycle read latency in a 2-entry buffer. It presents instructions to decode over a valid/ready handshake, with support for branch redirect, start and halt.

---
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the decode
// valid/ready channel. The master modport is the fetch unit's view.
interface fetch_if #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 20
);
  logic              imem_enable;
  logic              imem_read_writenot;
  logic [ADDR_W-1:0] imem_read_address;
  logic [INST_W-1:0] imem_data;
  logic              dec_valid;
  logic              dec_ready;
  logic [INST_W-1:0] dec_inst;
  logic [ADDR_W-1:0] dec_pc;

  modport master (
    output imem_enable, imem_read_writenot, imem_read_address,
    input  imem_data,
    output dec_valid, dec_inst, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_enable, imem_read_writenot, imem_read_address,
    output imem_data,
    input  dec_valid, dec_inst, dec_pc,
    output dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency memory and
// buffers returned words in a 2-entry FIFO feeding decode.
module fetch_unit #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_if.master           bus,
  output logic              dbg_state,
  output logic [1:0]        dbg_occ
);

  // Decode handshake: a word transfers on any cycle where dec_valid and
  // dec_ready are both high; dec_inst/dec_pc hold steady while dec_valid
  // is high and dec_ready is low. dec_valid never depends on dec_ready.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic              drop;
  logic [1:0]        occ;
  logic              rd_ptr, wr_ptr;
  logic [INST_W-1:0] fifo_inst [2];
  logic [ADDR_W-1:0] fifo_pc   [2];

  logic       dec_valid;
  logic       pop, push, issue;
  logic [2:0] credit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !halt) state_next = RUN;
      RUN:     if (halt)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign dec_valid = (occ != 2'd0) && !redirect;
  assign pop       = dec_valid && bus.dec_ready;
  // Words owed to the FIFO after this edge; issuing only below 2 keeps it from overflowing.
  assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && !halt && !redirect && (credit < 3'd2);
  // The word returning in a redirect cycle belongs to the old path.
  assign push      = inflight && !drop && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      drop        <= 1'b0;
      occ         <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(1);
      end
      if (redirect) pc <= redirect_pc;
      drop <= redirect && inflight;
      if (redirect) begin
        occ    <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_inst[wr_ptr] <= bus.imem_data;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

  assign bus.imem_enable        = issue;
  assign bus.imem_read_writenot = 1'b1;
  assign bus.imem_read_address  = pc;
  assign bus.dec_valid          = dec_valid;
  assign bus.dec_inst           = (occ != 2'd0) ? fifo_inst[rd_ptr] : '0;
  assign bus.dec_pc             = (occ != 2'd0) ? fifo_pc[rd_ptr]   : '0;

  assign dbg_state = (state == RUN);
  assign dbg_occ   = occ;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for reset/start/streaming, a scoreboard
// of expected {pc, inst} words, and directed backpressure/halt/redirect/reset.
module tb_fetch_unit;
  localparam int ADDR_W = 5;
  localparam int INST_W = 20;

  logic              clk = 1'b0;
  logic              rst, start, halt, redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dbg_state;
  logic [1:0]        dbg_occ;

  fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .bus(bus), .dbg_state(dbg_state), .dbg_occ(dbg_occ)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, garbage on the bus when not read.
  logic [INST_W-1:0] mem [32];
  always @(posedge clk)
    bus.imem_data <= bus.imem_enable ? mem[bus.imem_read_address] : INST_W'($urandom);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected {pc, inst}; mem[i] = i+1.
  logic [ADDR_W+INST_W-1:0] exp_q[$];
  logic                     sb_en = 1'b0;
  logic [ADDR_W-1:0]        last_pc = '0;

  task automatic push_range(input logic [ADDR_W-1:0] first, input int n);
    logic [ADDR_W-1:0] p;
    p = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, INST_W'(p) + INST_W'(1)});
      p = p + ADDR_W'(1);
    end
  endtask

  always @(negedge clk) begin
    if (sb_en && bus.dec_valid && bus.dec_ready) begin
      logic [ADDR_W+INST_W-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got pc %0d inst %0h, expected no transfer", bus.dec_pc, bus.dec_inst);
      end else begin
        e = exp_q.pop_front();
        last_pc = e[ADDR_W+INST_W-1:INST_W];
        if ({bus.dec_pc, bus.dec_inst} !== e) begin
          n_errors++;
          $display("FAIL sb_word: got pc %0d inst %0h, expected pc %0d inst %0h",
                   bus.dec_pc, bus.dec_inst, e[ADDR_W+INST_W-1:INST_W], e[INST_W-1:0]);
        end
      end
    end
  end

  typedef struct {
    logic              start, halt, ready;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              st;
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W+INST_W-1:0] head;
    logic [ADDR_W-1:0]        resume_pc;

    for (int i = 0; i < 32; i++) mem[i] = INST_W'(i + 1);

    // start+halt together stays idle, then start and stream pcs 0..3
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 20'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 20'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 20'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 20'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 20'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 20'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1, 20'd2};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 5'd2, 20'd3};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd3, 20'd4};

    rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_pc = '0; bus.dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_enable", 32'(bus.imem_enable), 32'd0);
    check("rst_addr", 32'(bus.imem_read_address), 32'd0);
    check("rst_rw", 32'(bus.imem_read_writenot), 32'd1);
    check("rst_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_inst", 32'(bus.dec_inst), 32'd0);
    check("rst_pc", 32'(bus.dec_pc), 32'd0);
    check("rst_occ", 32'(dbg_occ), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      start = vecs[i].start; halt = vecs[i].halt; bus.dec_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_en", i), 32'(bus.imem_enable), 32'(vecs[i].en));
      check($sformatf("tbl%0d_addr", i), 32'(bus.imem_read_address), 32'(vecs[i].addr));
      check($sformatf("tbl%0d_state", i), 32'(dbg_state), 32'(vecs[i].st));
      check($sformatf("tbl%0d_valid", i), 32'(bus.dec_valid), 32'(vecs[i].valid));
      check($sformatf("tbl%0d_pc", i), 32'(bus.dec_pc), 32'(vecs[i].pc));
      check($sformatf("tbl%0d_inst", i), 32'(bus.dec_inst), 32'(vecs[i].inst));
    end
    push_range(5'd4, 60);
    @(posedge clk); #1 sb_en = 1'b1;

    // Backpressure: two words buffered, issue stops, head held
    repeat (3) @(posedge clk);
    #1 bus.dec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      head = exp_q[0];
      check("bp_enable", 32'(bus.imem_enable), 32'd0);
      check("bp_valid", 32'(bus.dec_valid), 32'd1);
      check("bp_pc", 32'(bus.dec_pc), 32'(head[ADDR_W+INST_W-1:INST_W]));
      check("bp_inst", 32'(bus.dec_inst), 32'(head[INST_W-1:0]));
      if (k > 0) check("bp_occ", 32'(dbg_occ), 32'd2);
    end
    @(posedge clk); #1 bus.dec_ready = 1'b1;

    // Halt: no issue, drain, then resume from the first unfetched pc
    repeat (4) @(posedge clk);
    #1 halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("halt_enable", 32'(bus.imem_enable), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("halt_drained", 32'(bus.dec_valid), 32'd0);
    check("halt_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 halt = 1'b0; start = 1'b1;
    @(negedge clk);
    check("resume_idle_en", 32'(bus.imem_enable), 32'd0);
    resume_pc = last_pc + ADDR_W'(1);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("resume_en", 32'(bus.imem_enable), 32'd1);
    check("resume_addr", 32'(bus.imem_read_address), 32'(resume_pc));

    // Redirect to 30 with a word buffered and one in flight
    repeat (5) @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 5'd30;
    @(negedge clk);
    check("redir_valid", 32'(bus.dec_valid), 32'd0);
    check("redir_enable", 32'(bus.imem_enable), 32'd0);
    check("redir_occ_busy", 32'(dbg_occ != 2'd0), 32'd1);
    exp_q.delete();
    push_range(5'd30, 40);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("redir_r1_en", 32'(bus.imem_enable), 32'd1);
    check("redir_r1_addr", 32'(bus.imem_read_address), 32'd30);
    check("redir_r1_valid", 32'(bus.dec_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check("redir_r2_valid", 32'(bus.dec_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check("redir_r3_valid", 32'(bus.dec_valid), 32'd1);
    check("redir_r3_pc", 32'(bus.dec_pc), 32'd30);
    repeat (4) @(posedge clk);

    // Reset mid-stream with a read in flight
    #1 bus.dec_ready = 1'b0; sb_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.dec_ready = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(bus.dec_valid), 32'd0);
    check("mrst_enable", 32'(bus.imem_enable), 32'd0);
    check("mrst_addr", 32'(bus.imem_read_address), 32'd0);
    check("mrst_occ", 32'(dbg_occ), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); @(negedge clk);
    check("mrst_nostale_valid", 32'(bus.dec_valid), 32'd0);
    check("mrst_nostale_occ", 32'(dbg_occ), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
